// File: rtl/rs_issue_scheduler.sv
// Reservation station with round-robin issue to one shared functional unit.
// Entries snoop the CDB for outstanding operand tags; one operand-ready
// entry is dispatched per opportunity, with a one-cycle holdoff after each
// dispatch so the unit has time to drop its availability.
module rs_issue_scheduler #(
  parameter int N        = 3,
  parameter int TAG_W    = 3,
  parameter int TAG_BASE = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [3:0]             inOp,
  input  logic [15:0]            inVj,
  input  logic [15:0]            inVk,
  input  logic [TAG_W-1:0]       inQj,
  input  logic [TAG_W-1:0]       inQk,
  output logic [TAG_W-1:0]       inTag,
  input  logic                   cdbValid,
  input  logic [TAG_W-1:0]       cdbTag,
  input  logic [15:0]            cdbValue,
  input  logic                   fuAvail,
  output logic                   fuIssue,
  output logic [3:0]             fuOp,
  output logic [15:0]            fuR2,
  output logic [15:0]            fuR1,
  output logic [TAG_W-1:0]       fuTag,
  output logic [$clog2(N+1)-1:0] occupancy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int OCC_W = $clog2(N + 1);
  localparam logic [TAG_W-1:0] TAG_BASE_T = TAG_W'(TAG_BASE);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N - 1);

  // Per-entry state
  logic [N-1:0]       busy_q, busy_d;
  logic [3:0]         op_q [N];
  logic [3:0]         op_d [N];
  logic [15:0]        vj_q [N];
  logic [15:0]        vj_d [N];
  logic [15:0]        vk_q [N];
  logic [15:0]        vk_d [N];
  logic [TAG_W-1:0]   qj_q [N];
  logic [TAG_W-1:0]   qj_d [N];
  logic [TAG_W-1:0]   qk_q [N];
  logic [TAG_W-1:0]   qk_d [N];

  // Scheduler and dispatch output registers
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               fu_issue_q, fu_issue_d;
  logic [3:0]         fu_op_q, fu_op_d;
  logic [15:0]        fu_r2_q, fu_r2_d;
  logic [15:0]        fu_r1_q, fu_r1_d;
  logic [TAG_W-1:0]   fu_tag_q, fu_tag_d;

  logic [N-1:0]       ready;
  logic               any_free;
  logic [IDX_W-1:0]   free_idx;
  logic               disp_found;
  logic [IDX_W-1:0]   disp_idx;
  logic               disp_en;
  logic               alloc_en;
  logic               cdb_hit;
  logic [OCC_W-1:0]   occ_count;

  // An entry may dispatch only when both operands are already captured.
  for (genvar gi = 0; gi < N; gi++) begin : g_ready
    assign ready[gi] = busy_q[gi] && (qj_q[gi] == '0) && (qk_q[gi] == '0);
  end

  assign cdb_hit = cdbValid && (cdbTag != '0);

  // Lowest-index free entry receives the next allocation.
  always_comb begin
    free_idx = '0;
    any_free = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!busy_q[IDX_W'(i)]) begin
        free_idx = IDX_W'(i);
        any_free = 1'b1;
      end
    end
  end

  // Round-robin pick: first ready entry at or after rr_ptr, wrapping mod N.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand       = '0;
    disp_idx   = '0;
    disp_found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr_q) + k) % N);
      if (ready[cand]) begin
        disp_idx   = cand;
        disp_found = 1'b1;
      end
    end
  end

  assign disp_en  = fuAvail && !fu_issue_q && disp_found;
  assign alloc_en = inValid && any_free;

  // Busy-entry count for the occupancy output.
  always_comb begin
    occ_count = '0;
    for (int i = 0; i < N; i++) begin
      if (busy_q[IDX_W'(i)]) occ_count = occ_count + 1'b1;
    end
  end

  // Next state: CDB wake-up, dispatch, then allocation with forwarding.
  always_comb begin
    logic [IDX_W-1:0] ei;
    ei         = '0;
    busy_d     = busy_q;
    op_d       = op_q;
    vj_d       = vj_q;
    vk_d       = vk_q;
    qj_d       = qj_q;
    qk_d       = qk_q;
    rr_ptr_d   = rr_ptr_q;
    fu_issue_d = disp_en;
    fu_op_d    = fu_op_q;
    fu_r2_d    = fu_r2_q;
    fu_r1_d    = fu_r1_q;
    fu_tag_d   = fu_tag_q;

    for (int i = 0; i < N; i++) begin
      ei = IDX_W'(i);
      if (busy_q[ei] && cdb_hit) begin
        if (qj_q[ei] == cdbTag) begin
          vj_d[ei] = cdbValue;
          qj_d[ei] = '0;
        end
        if (qk_q[ei] == cdbTag) begin
          vk_d[ei] = cdbValue;
          qk_d[ei] = '0;
        end
      end
    end

    if (disp_en) begin
      busy_d[disp_idx] = 1'b0;
      fu_op_d  = op_q[disp_idx];
      fu_r2_d  = vj_q[disp_idx];
      fu_r1_d  = vk_q[disp_idx];
      fu_tag_d = TAG_BASE_T + TAG_W'(disp_idx);
      rr_ptr_d = (disp_idx == LAST_IDX) ? '0 : disp_idx + 1'b1;
    end

    // The allocated slot was free before the edge, so it never collides
    // with the dispatched or woken entries above.
    if (alloc_en) begin
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = inOp;
      if (cdb_hit && (inQj == cdbTag)) begin
        vj_d[free_idx] = cdbValue;
        qj_d[free_idx] = '0;
      end else begin
        vj_d[free_idx] = inVj;
        qj_d[free_idx] = inQj;
      end
      if (cdb_hit && (inQk == cdbTag)) begin
        vk_d[free_idx] = cdbValue;
        qk_d[free_idx] = '0;
      end else begin
        vk_d[free_idx] = inVk;
        qk_d[free_idx] = inQk;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q     <= '0;
      op_q       <= '{default: '0};
      vj_q       <= '{default: '0};
      vk_q       <= '{default: '0};
      qj_q       <= '{default: '0};
      qk_q       <= '{default: '0};
      rr_ptr_q   <= '0;
      fu_issue_q <= 1'b0;
      fu_op_q    <= '0;
      fu_r2_q    <= '0;
      fu_r1_q    <= '0;
      fu_tag_q   <= '0;
    end else begin
      busy_q     <= busy_d;
      op_q       <= op_d;
      vj_q       <= vj_d;
      vk_q       <= vk_d;
      qj_q       <= qj_d;
      qk_q       <= qk_d;
      rr_ptr_q   <= rr_ptr_d;
      fu_issue_q <= fu_issue_d;
      fu_op_q    <= fu_op_d;
      fu_r2_q    <= fu_r2_d;
      fu_r1_q    <= fu_r1_d;
      fu_tag_q   <= fu_tag_d;
    end
  end

  assign inReady   = any_free;
  assign inTag     = any_free ? (TAG_BASE_T + TAG_W'(free_idx)) : '0;
  assign fuIssue   = fu_issue_q;
  assign fuOp      = fu_op_q;
  assign fuR2      = fu_r2_q;
  assign fuR1      = fu_r1_q;
  assign fuTag     = fu_tag_q;
  assign occupancy = occ_count;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Bench for rs_issue_scheduler: directed scenarios with constant expectations,
// then randomized traffic compared cycle by cycle against a behavioural model.
module tb_rs_issue_scheduler;
  localparam int N      = 3;
  localparam int TAG_W  = 3;
  localparam int TBASE  = 1;
  localparam int OCC_W  = $clog2(N + 1);

  logic             clock = 1'b0;
  logic             reset;
  logic             inValid;
  logic             inReady;
  logic [3:0]       inOp;
  logic [15:0]      inVj, inVk;
  logic [TAG_W-1:0] inQj, inQk;
  logic [TAG_W-1:0] inTag;
  logic             cdbValid;
  logic [TAG_W-1:0] cdbTag;
  logic [15:0]      cdbValue;
  logic             fuAvail;
  logic             fuIssue;
  logic [3:0]       fuOp;
  logic [15:0]      fuR2, fuR1;
  logic [TAG_W-1:0] fuTag;
  logic [OCC_W-1:0] occupancy;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state: plain integers per station slot.
  int m_busy[N], m_op[N], m_vj[N], m_vk[N], m_qj[N], m_qk[N];
  int m_rr, m_issue, m_fop, m_r1, m_r2, m_ftag;

  rs_issue_scheduler #(.N(N), .TAG_W(TAG_W), .TAG_BASE(TBASE)) dut (
    .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
    .inOp(inOp), .inVj(inVj), .inVk(inVk), .inQj(inQj), .inQk(inQk),
    .inTag(inTag), .cdbValid(cdbValid), .cdbTag(cdbTag), .cdbValue(cdbValue),
    .fuAvail(fuAvail), .fuIssue(fuIssue), .fuOp(fuOp), .fuR2(fuR2),
    .fuR1(fuR1), .fuTag(fuTag), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  function automatic int model_free();
    for (int i = 0; i < N; i++) if (m_busy[i] == 0) return i;
    return -1;
  endfunction

  function automatic int model_occ();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_busy[i];
    return c;
  endfunction

  function automatic int model_in_tag();
    int f = model_free();
    return (f < 0) ? 0 : TBASE + f;
  endfunction

  // Apply the station's rules to the model for the upcoming edge.
  task automatic model_step();
    int pick, free, ct;
    bit cdb_ok;
    if (reset == 1'b0) begin
      for (int i = 0; i < N; i++) begin
        m_busy[i] = 0; m_op[i] = 0; m_vj[i] = 0; m_vk[i] = 0; m_qj[i] = 0; m_qk[i] = 0;
      end
      m_rr = 0; m_issue = 0; m_fop = 0; m_r1 = 0; m_r2 = 0; m_ftag = 0;
      return;
    end
    cdb_ok = cdbValid && (cdbTag != 0);
    ct = int'(cdbTag);
    pick = -1;
    if (fuAvail && m_issue == 0) begin
      for (int k = 0; k < N; k++) begin
        int j = (m_rr + k) % N;
        if (pick < 0 && m_busy[j] == 1 && m_qj[j] == 0 && m_qk[j] == 0) pick = j;
      end
    end
    free = model_free();
    if (cdb_ok) begin
      for (int i = 0; i < N; i++) begin
        if (m_busy[i] == 1 && m_qj[i] == ct) begin m_vj[i] = int'(cdbValue); m_qj[i] = 0; end
        if (m_busy[i] == 1 && m_qk[i] == ct) begin m_vk[i] = int'(cdbValue); m_qk[i] = 0; end
      end
    end
    if (pick >= 0) begin
      m_busy[pick] = 0;
      m_issue = 1; m_fop = m_op[pick]; m_r2 = m_vj[pick]; m_r1 = m_vk[pick];
      m_ftag = TBASE + pick;
      m_rr = (pick + 1) % N;
    end else begin
      m_issue = 0;
    end
    if (inValid && free >= 0) begin
      m_busy[free] = 1;
      m_op[free] = int'(inOp);
      if (cdb_ok && int'(inQj) == ct) begin m_vj[free] = int'(cdbValue); m_qj[free] = 0; end
      else begin m_vj[free] = int'(inVj); m_qj[free] = int'(inQj); end
      if (cdb_ok && int'(inQk) == ct) begin m_vk[free] = int'(cdbValue); m_qk[free] = 0; end
      else begin m_vk[free] = int'(inVk); m_qk[free] = int'(inQk); end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    inValid = 0; inOp = 0; inVj = 0; inVk = 0; inQj = 0; inQk = 0;
    cdbValid = 0; cdbTag = 0; cdbValue = 0;
  endtask

  task automatic drive_in(input int op, input int vj, input int vk, input int qj, input int qk);
    inValid = 1; inOp = 4'(op); inVj = 16'(vj); inVk = 16'(vk);
    inQj = TAG_W'(qj); inQk = TAG_W'(qk);
  endtask

  task automatic do_reset();
    reset = 0;
    tick();
    reset = 1;
  endtask

  task automatic test_reset();
    drive_idle(); fuAvail = 0;
    do_reset();
    checks++; if (fuIssue !== 1'b0) begin failures++; $display("FAIL rst_issue got=%0d exp=0", fuIssue); end
    checks++; if (occupancy !== 0) begin failures++; $display("FAIL rst_occ got=%0d exp=0", occupancy); end
    checks++; if (inReady !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0d exp=1", inReady); end
    checks++; if (inTag !== 3'd1) begin failures++; $display("FAIL rst_intag got=%0d exp=1", inTag); end
    checks++; if ({fuOp, fuR1, fuR2, fuTag} !== '0) begin failures++; $display("FAIL rst_fu_regs got=%h exp=0", {fuOp, fuR1, fuR2, fuTag}); end
  endtask

  task automatic test_ready_dispatch();
    do_reset(); fuAvail = 1;
    drive_in(0, 5, 3, 0, 0);
    tick();
    drive_idle();
    checks++; if (fuIssue !== 1'b0) begin failures++; $display("FAIL rd_early got=%0d exp=0", fuIssue); end
    tick();
    checks++; if (fuIssue !== 1'b1) begin failures++; $display("FAIL rd_issue got=%0d exp=1", fuIssue); end
    checks++; if (fuR2 !== 16'd5 || fuR1 !== 16'd3) begin failures++; $display("FAIL rd_ops got=%0d,%0d exp=5,3", fuR2, fuR1); end
    checks++; if (fuTag !== 3'd1 || fuOp !== 4'd0) begin failures++; $display("FAIL rd_tagop got=%0d,%0d exp=1,0", fuTag, fuOp); end
    checks++; if (occupancy !== 0) begin failures++; $display("FAIL rd_occ got=%0d exp=0", occupancy); end
    tick();
    checks++; if (fuIssue !== 1'b0) begin failures++; $display("FAIL rd_pulse got=%0d exp=0", fuIssue); end
  endtask

  task automatic test_wakeup();
    do_reset(); fuAvail = 1;
    drive_in(2, 16'hDEAD, 7, 2, 0);
    tick();
    drive_idle();
    tick(); tick();
    checks++; if (fuIssue !== 1'b0) begin failures++; $display("FAIL wk_wait got=%0d exp=0", fuIssue); end
    cdbValid = 1; cdbTag = 2; cdbValue = 16'h0010;
    tick();
    drive_idle();
    checks++; if (fuIssue !== 1'b0) begin failures++; $display("FAIL wk_same_edge got=%0d exp=0", fuIssue); end
    tick();
    checks++; if (fuIssue !== 1'b1 || fuR2 !== 16'h0010 || fuR1 !== 16'd7) begin failures++; $display("FAIL wk_dispatch got=%0d,%h,%h exp=1,0010,0007", fuIssue, fuR2, fuR1); end
  endtask

  task automatic test_forwarding();
    do_reset(); fuAvail = 1;
    drive_in(2, 16'hBEEF, 7, 2, 0);
    cdbValid = 1; cdbTag = 2; cdbValue = 16'h0010;
    tick();
    drive_idle();
    tick();
    checks++; if (fuIssue !== 1'b1 || fuR2 !== 16'h0010 || fuR1 !== 16'd7) begin failures++; $display("FAIL fw_dispatch got=%0d,%h,%h exp=1,0010,0007", fuIssue, fuR2, fuR1); end
  endtask

  task automatic test_round_robin();
    int exp_issue[6] = '{1, 0, 1, 0, 1, 0};
    int exp_tag[6]   = '{2, 2, 3, 3, 1, 1};
    do_reset(); fuAvail = 0;
    for (int i = 0; i < 3; i++) begin
      drive_in(i, 16'h100 + i, 16'h200 + i, 0, 0);
      tick();
    end
    drive_idle(); fuAvail = 1;
    tick();
    checks++; if (fuIssue !== 1'b1 || fuTag !== 3'd1 || fuR2 !== 16'h100) begin failures++; $display("FAIL rr_first got=%0d,%0d,%h exp=1,1,0100", fuIssue, fuTag, fuR2); end
    drive_in(9, 16'h300, 16'h301, 0, 0);
    checks++; if (inTag !== 3'd1) begin failures++; $display("FAIL rr_refill_tag got=%0d exp=1", inTag); end
    tick();
    drive_idle();
    checks++; if (fuIssue !== 1'b0) begin failures++; $display("FAIL rr_holdoff got=%0d exp=0", fuIssue); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (fuIssue !== 1'(exp_issue[c]) || fuTag !== TAG_W'(exp_tag[c])) begin
        failures++;
        $display("FAIL rr_seq%0d got=%0d/%0d exp=%0d/%0d", c, fuIssue, fuTag, exp_issue[c], exp_tag[c]);
      end
    end
    checks++; if (fuR2 !== 16'h300 || fuOp !== 4'd9) begin failures++; $display("FAIL rr_refill_data got=%h,%0d exp=0300,9", fuR2, fuOp); end
  endtask

  task automatic test_full();
    do_reset(); fuAvail = 0;
    drive_in(1, 16'h11, 16'h22, 0, 0);
    tick(); tick(); tick();
    checks++; if (inReady !== 1'b0 || occupancy !== 3) begin failures++; $display("FAIL full_state got=%0d,%0d exp=0,3", inReady, occupancy); end
    tick();
    checks++; if (occupancy !== 3) begin failures++; $display("FAIL full_no4th got=%0d exp=3", occupancy); end
    fuAvail = 1;
    tick();
    checks++; if (fuIssue !== 1'b1 || occupancy !== 2) begin failures++; $display("FAIL full_disp got=%0d,%0d exp=1,2", fuIssue, occupancy); end
    checks++; if (inReady !== 1'b1 || inTag !== 3'd1) begin failures++; $display("FAIL full_freed got=%0d,%0d exp=1,1", inReady, inTag); end
    tick();
    checks++; if (occupancy !== 3 || inReady !== 1'b0 || fuIssue !== 1'b0) begin failures++; $display("FAIL full_realloc got=%0d,%0d,%0d exp=3,0,0", occupancy, inReady, fuIssue); end
    drive_idle(); fuAvail = 0;
  endtask

  task automatic test_fu_unavail();
    do_reset(); fuAvail = 0;
    drive_in(3, 16'h1111, 9, 3, 0);
    tick();
    drive_in(4, 16'h22, 16'h33, 0, 0);
    cdbValid = 1; cdbTag = 0; cdbValue = 16'hAAAA;
    tick();
    drive_idle();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (fuIssue !== 1'b0 || occupancy !== 2) begin failures++; $display("FAIL un_hold%0d got=%0d,%0d exp=0,2", c, fuIssue, occupancy); end
    end
    fuAvail = 1;
    tick();
    checks++; if (fuIssue !== 1'b1 || fuTag !== 3'd2 || fuR2 !== 16'h22 || fuR1 !== 16'h33) begin failures++; $display("FAIL un_disp got=%0d,%0d,%h,%h exp=1,2,0022,0033", fuIssue, fuTag, fuR2, fuR1); end
    tick(); tick();
    checks++; if (fuIssue !== 1'b0 || occupancy !== 1) begin failures++; $display("FAIL un_tag0 got=%0d,%0d exp=0,1", fuIssue, occupancy); end
    checks++; if (fuR2 !== 16'h22 || fuTag !== 3'd2) begin failures++; $display("FAIL un_held got=%h,%0d exp=0022,2", fuR2, fuTag); end
    cdbValid = 1; cdbTag = 3; cdbValue = 16'h0055;
    tick();
    drive_idle();
    tick();
    checks++; if (fuIssue !== 1'b1 || fuTag !== 3'd1 || fuR2 !== 16'h55 || fuR1 !== 16'd9 || fuOp !== 4'd3) begin failures++; $display("FAIL un_wake got=%0d,%0d,%h,%h,%0d exp=1,1,0055,0009,3", fuIssue, fuTag, fuR2, fuR1, fuOp); end
  endtask

  task automatic test_reset_mid();
    do_reset(); fuAvail = 0;
    for (int i = 0; i < 3; i++) begin
      drive_in(5, 16'h40 + i, 16'h50 + i, 0, 0);
      tick();
    end
    drive_idle(); fuAvail = 1;
    tick(); tick();
    reset = 0;
    drive_in(6, 1, 2, 0, 0);
    cdbValid = 1; cdbTag = 1; cdbValue = 16'h9999;
    tick();
    reset = 1;
    drive_idle();
    checks++; if (fuIssue !== 1'b0 || occupancy !== 0) begin failures++; $display("FAIL mid_clear got=%0d,%0d exp=0,0", fuIssue, occupancy); end
    checks++; if (inReady !== 1'b1 || inTag !== 3'd1 || fuTag !== 3'd0) begin failures++; $display("FAIL mid_ready got=%0d,%0d,%0d exp=1,1,0", inReady, inTag, fuTag); end
    fuAvail = 0;
    drive_in(7, 16'h70, 16'h80, 0, 0); tick();
    drive_in(7, 16'h71, 16'h81, 0, 0); tick();
    drive_idle(); fuAvail = 1;
    tick();
    checks++; if (fuIssue !== 1'b1 || fuTag !== 3'd1 || fuR2 !== 16'h70) begin failures++; $display("FAIL mid_rr got=%0d,%0d,%h exp=1,1,0070", fuIssue, fuTag, fuR2); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 99) != 0);
      inValid  = ($urandom_range(0, 1) != 0);
      inOp     = 4'($urandom_range(0, 15));
      inVj     = 16'($urandom);
      inVk     = 16'($urandom);
      inQj     = ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 7)) : '0;
      inQk     = ($urandom_range(0, 2) == 0) ? TAG_W'($urandom_range(1, 7)) : '0;
      cdbValid = ($urandom_range(0, 1) != 0);
      cdbTag   = TAG_W'($urandom_range(0, 7));
      cdbValue = 16'($urandom);
      fuAvail  = ($urandom_range(0, 3) != 0);
      tick();
      checks++; if (fuIssue !== 1'(m_issue)) begin failures++; $display("FAIL rnd%0d fuIssue got=%0d exp=%0d", c, fuIssue, m_issue); end
      checks++; if (fuOp !== 4'(m_fop)) begin failures++; $display("FAIL rnd%0d fuOp got=%0d exp=%0d", c, fuOp, m_fop); end
      checks++; if (fuR2 !== 16'(m_r2)) begin failures++; $display("FAIL rnd%0d fuR2 got=%h exp=%h", c, fuR2, m_r2); end
      checks++; if (fuR1 !== 16'(m_r1)) begin failures++; $display("FAIL rnd%0d fuR1 got=%h exp=%h", c, fuR1, m_r1); end
      checks++; if (fuTag !== TAG_W'(m_ftag)) begin failures++; $display("FAIL rnd%0d fuTag got=%0d exp=%0d", c, fuTag, m_ftag); end
      checks++; if (occupancy !== OCC_W'(model_occ())) begin failures++; $display("FAIL rnd%0d occupancy got=%0d exp=%0d", c, occupancy, model_occ()); end
      checks++; if (inReady !== (model_free() >= 0)) begin failures++; $display("FAIL rnd%0d inReady got=%0d exp=%0d", c, inReady, model_free() >= 0); end
      checks++; if (inTag !== TAG_W'(model_in_tag())) begin failures++; $display("FAIL rnd%0d inTag got=%0d exp=%0d", c, inTag, model_in_tag()); end
    end
    reset = 1;
    drive_idle();
  endtask

  initial begin
    reset = 0;
    fuAvail = 0;
    drive_idle();
    test_reset();
    test_ready_dispatch();
    test_wakeup();
    test_forwarding();
    test_round_robin();
    test_full();
    test_fu_unavail();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
